// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: NREQ one-entry holding slots drained round-robin,
// one per cycle, into a registered write/retire stage.
module wb_port_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ-1:0]      req_regw_i,
    input  logic [NREQ*AW-1:0]   req_rd_i,
    input  logic [NREQ*XLEN-1:0] req_data_i,
    output logic                 rf_wen_o,
    output logic [AW-1:0]        rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic                 retire_o,
    output logic [1:0]           retire_src_o
);

    if (NREQ < 2 || NREQ > 4) begin : gen_nreq_check
        $error("wb_port_arbiter: NREQ must be in 2..4");
    end

    logic [NREQ-1:0] full_q, full_d;
    logic [NREQ-1:0] regw_q, regw_d;
    logic [AW-1:0]   rd_q   [NREQ];
    logic [AW-1:0]   rd_d   [NREQ];
    logic [XLEN-1:0] data_q [NREQ];
    logic [XLEN-1:0] data_d [NREQ];
    logic [1:0]      rr_ptr_q, rr_ptr_d;

    logic            rf_wen_q, rf_wen_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            retire_q, retire_d;
    logic [1:0]      retire_src_q, retire_src_d;

    logic            grant_found;
    logic            grant;
    logic [1:0]      grant_idx;
    logic [1:0]      cand;
    logic [NREQ-1:0] grant_oh;

    // Round-robin search starting just after the last winner; only slots already
    // full before this edge take part, so a fresh entry waits one cycle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 2'((32'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && full_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_found & ~flush_i;

    always_comb begin
        grant_oh = '0;
        if (grant) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready_o = {NREQ{~flush_i}} & (~full_q | grant_oh);

    always_comb begin
        full_d = full_q;
        regw_d = regw_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (flush_i) begin
            full_d = '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    full_d[i] = 1'b1;
                    regw_d[i] = req_regw_i[i];
                    rd_d[i]   = req_rd_i[i*AW +: AW];
                    data_d[i] = req_data_i[i*XLEN +: XLEN];
                end else if (grant_oh[i]) begin
                    full_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rf_wen_d     = 1'b0;
        retire_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_src_d = retire_src_q;
        if (grant) begin
            rr_ptr_d     = grant_idx;
            retire_d     = 1'b1;
            retire_src_d = grant_idx;
            rf_waddr_d   = rd_q[grant_idx];
            rf_wdata_d   = data_q[grant_idx];
            // x0 is never written but the instruction still retires
            rf_wen_d     = regw_q[grant_idx] & (rd_q[grant_idx] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q       <= '0;
            regw_q       <= '0;
            rr_ptr_q     <= 2'(NREQ - 1);
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_q     <= 1'b0;
            retire_src_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q       <= full_d;
            regw_q       <= regw_d;
            rr_ptr_q     <= rr_ptr_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_q     <= retire_d;
            retire_src_q <= retire_src_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rf_wen_o     = rf_wen_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign retire_o     = retire_q;
    assign retire_src_o = retire_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level slot model.
module tb_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [NREQ-1:0]      v_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      v_regw;
    logic [NREQ*AW-1:0]   v_rd;
    logic [NREQ*XLEN-1:0] v_data;
    logic                 rf_wen;
    logic [AW-1:0]        rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 retire;
    logic [1:0]           retire_src;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .req_valid_i  (v_valid),
        .req_ready_o  (req_ready),
        .req_regw_i   (v_regw),
        .req_rd_i     (v_rd),
        .req_data_i   (v_data),
        .rf_wen_o     (rf_wen),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .retire_o     (retire),
        .retire_src_o (retire_src)
    );

    // Model: what each requester's slot holds, who won last, and the write stage.
    bit          m_full [NREQ];
    bit          m_regw [NREQ];
    logic [AW-1:0]   m_rd   [NREQ];
    logic [XLEN-1:0] m_data [NREQ];
    int          m_last;
    bit          m_wen, m_retire;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    int          m_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 0;
            m_regw[i] = 0;
            m_rd[i]   = '0;
            m_data[i] = '0;
        end
        m_last   = NREQ - 1;
        m_wen    = 0;
        m_retire = 0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_src    = 0;
    endtask

    // One clock: inputs are already set; check ready, advance model at the edge,
    // then compare the registered outputs at the following negedge.
    task automatic step();
        int winner;
        logic [NREQ-1:0] m_ready;
        logic [NREQ-1:0] acc;
        #1;
        winner = -1;
        if (!flush) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (winner < 0 && m_full[j]) winner = j;
            end
        end
        for (int i = 0; i < NREQ; i++) m_ready[i] = !flush && (!m_full[i] || winner == i);
        if (rst) begin
            check("req_ready", 64'(req_ready), 64'(m_ready));
            if (flush) check("ready_during_flush", 64'(req_ready), 64'd0);
        end
        acc = v_valid & m_ready & {NREQ{rst}};
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (winner >= 0) begin
                m_retire = 1;
                m_src    = winner;
                m_waddr  = m_rd[winner];
                m_wdata  = m_data[winner];
                m_wen    = m_regw[winner] && (m_rd[winner] != 0);
                m_last   = winner;
            end else begin
                m_wen    = 0;
                m_retire = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (flush) m_full[i] = 0;
                else if (acc[i]) begin
                    m_full[i] = 1;
                    m_regw[i] = v_regw[i];
                    m_rd[i]   = v_rd[i*AW +: AW];
                    m_data[i] = v_data[i*XLEN +: XLEN];
                end else if (winner == i) m_full[i] = 0;
            end
        end
        @(negedge clk);
        check("rf_wen", 64'(rf_wen), 64'(m_wen));
        check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("retire", 64'(retire), 64'(m_retire));
        check("retire_src", 64'(retire_src), 64'(m_src));
        v_valid = v_valid & ~acc;
    endtask

    task automatic offer(input int i, input logic regw, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] data);
        v_valid[i]              = 1'b1;
        v_regw[i]               = regw;
        v_rd[i*AW +: AW]        = rd;
        v_data[i*XLEN +: XLEN]  = data;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        flush   = 1'b0;
        v_valid = '0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        flush   = 1'b0;
        v_valid = '0;
        v_regw  = '0;
        v_rd    = '0;
        v_data  = '0;
        model_reset();

        // T1: single write, two edges of latency, then idle
        do_reset();
        check("t1_reset_wen", 64'(rf_wen), 64'd0);
        check("t1_reset_waddr", 64'(rf_waddr), 64'd0);
        offer(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("t1_no_early_retire", 64'(retire), 64'd0);
        step();
        check("t1_wen", 64'(rf_wen), 64'd1);
        check("t1_waddr", 64'(rf_waddr), 64'd5);
        check("t1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        check("t1_retire", 64'(retire), 64'd1);
        step();
        check("t1_idle_retire", 64'(retire), 64'd0);
        check("t1_idle_wen", 64'(rf_wen), 64'd0);
        check("t1_addr_holds", 64'(rf_waddr), 64'd5);

        // T2: full contention, strict rotation 0,1,2,...
        do_reset();
        for (int cyc = 0; cyc < 9; cyc++) begin
            for (int i = 0; i < NREQ; i++)
                if (!v_valid[i]) offer(i, 1'b1, 5'(i + 1), $urandom);
            step();
            if (cyc >= 1) begin
                check("t2_retire_src", 64'(retire_src), 64'((cyc - 1) % 3));
                check("t2_wen", 64'(rf_wen), 64'd1);
            end
        end
        v_valid = '0;

        // T3: write to x0 is suppressed but retires
        do_reset();
        offer(1, 1'b1, 5'd0, 32'h1234);
        step();
        step();
        check("t3_retire", 64'(retire), 64'd1);
        check("t3_src", 64'(retire_src), 64'd1);
        check("t3_wen", 64'(rf_wen), 64'd0);
        check("t3_wdata", 64'(rf_wdata), 64'h1234);

        // T4: retire-only result from req2
        do_reset();
        offer(2, 1'b0, 5'd9, 32'h5555);
        step();
        check("t4_ready_at_grant", 64'(req_ready[2]), 64'd1);
        step();
        check("t4_retire", 64'(retire), 64'd1);
        check("t4_src", 64'(retire_src), 64'd2);
        check("t4_wen", 64'(rf_wen), 64'd0);

        // T5: flush drops queued slot, in-flight write completes
        do_reset();
        offer(0, 1'b1, 5'd7, 32'hA1);
        offer(1, 1'b1, 5'd8, 32'hB2);
        step();
        step();
        check("t5_inflight_wen", 64'(rf_wen), 64'd1);
        check("t5_inflight_addr", 64'(rf_waddr), 64'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_flush_retire", 64'(retire), 64'd0);
        step();
        check("t5_after_retire", 64'(retire), 64'd0);
        check("t5_after_ready", 64'(req_ready), 64'b111);

        // T6: reset mid-operation
        do_reset();
        offer(0, 1'b1, 5'd3, 32'h30);
        offer(1, 1'b1, 5'd4, 32'h40);
        offer(2, 1'b1, 5'd6, 32'h60);
        step();
        step();
        check("t6_pre_wen", 64'(rf_wen), 64'd1);
        rst     = 1'b0;
        v_valid = '0;
        step();
        check("t6_rst_wen", 64'(rf_wen), 64'd0);
        check("t6_rst_retire", 64'(retire), 64'd0);
        check("t6_rst_waddr", 64'(rf_waddr), 64'd0);
        check("t6_rst_wdata", 64'(rf_wdata), 64'd0);
        check("t6_rst_src", 64'(retire_src), 64'd0);
        rst = 1'b1;
        step();
        check("t6_empty_retire", 64'(retire), 64'd0);
        offer(1, 1'b1, 5'd11, 32'h11);
        offer(0, 1'b1, 5'd10, 32'h10);
        step();
        step();
        check("t6_first_src", 64'(retire_src), 64'd0);
        check("t6_first_retire", 64'(retire), 64'd1);

        // Randomized traffic with occasional flush and reset
        do_reset();
        repeat (3000) begin
            rst   = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 19) == 0);
            if (!rst) begin
                v_valid = '0;
            end else begin
                for (int i = 0; i < NREQ; i++)
                    if (!v_valid[i] && $urandom_range(0, 1) == 1)
                        offer(i, ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)),
                              $urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
